// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: owns the PC, keeps at most one imem read in flight and feeds decode through a 1-entry skid buffer.
// Optional macro FETCH_PERF_EN adds the o_fetch_count / o_redirect_count performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_pc_ctrl,
    input  logic        i_stall,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jalr_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst_out,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_valid,
    output logic        o_misalign
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_redirect_count
`endif
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_ISSUE,
        S_WAIT,
        S_WAIT_KILL
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;

    logic        w_redirect;
    logic [31:0] w_raw_target;
    logic [31:0] w_target;
    logic        w_in_wait;
    logic        w_deliver;
    logic        w_accept;

    // pc_ctrl 2 (JALR) and 3 (branch/JAL) both redirect; bit 0 picks the target source
    assign w_redirect   = i_pc_ctrl[1];
    assign w_raw_target = i_pc_ctrl[0] ? i_branch_target : i_jalr_target;
    assign w_target     = {w_raw_target[31:2], 2'b00};

    assign w_in_wait  = (r_state == S_WAIT) || (r_state == S_WAIT_KILL);
    assign o_imem_req = (r_state == S_ISSUE) && !w_redirect
                        && (i_pc_ctrl != 2'd1) && !r_skid_valid;
    assign w_accept   = o_imem_req && i_imem_ready;
    assign w_deliver  = i_imem_rvalid && (r_state == S_WAIT) && !w_redirect;
    assign o_imem_addr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT:      w_next_state = S_ISSUE;
            S_ISSUE:     if (w_accept) w_next_state = S_WAIT;
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    w_next_state = S_ISSUE;
                end else if (w_redirect) begin
                    w_next_state = S_WAIT_KILL;
                end
            end
            S_WAIT_KILL: if (i_imem_rvalid) w_next_state = S_ISSUE;
            default:     w_next_state = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= 32'h0;
            o_misalign <= 1'b0;
        end else begin
            o_misalign <= w_redirect && (w_raw_target[1:0] != 2'b00);
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
        end
    end

    // A response landing during a stall parks in the skid entry; it drains first once decode moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_inst_out   <= NOP_INST;
            o_inst_pc    <= 32'h0;
            o_inst_valid <= 1'b0;
            r_skid_inst  <= 32'h0;
            r_skid_pc    <= 32'h0;
            r_skid_valid <= 1'b0;
        end else if (w_redirect) begin
            o_inst_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_stall) begin
            if (w_deliver) begin
                r_skid_inst  <= i_imem_rdata;
                r_skid_pc    <= r_req_pc;
                r_skid_valid <= 1'b1;
            end
        end else if (r_skid_valid) begin
            o_inst_out   <= r_skid_inst;
            o_inst_pc    <= r_skid_pc;
            o_inst_valid <= 1'b1;
            r_skid_valid <= 1'b0;
        end else if (w_deliver) begin
            o_inst_out   <= i_imem_rdata;
            o_inst_pc    <= r_req_pc;
            o_inst_valid <= 1'b1;
        end else begin
            o_inst_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic w_load;

    assign w_load = !w_redirect && !i_stall && (r_skid_valid || w_deliver);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fetch_count    <= 32'h0;
            o_redirect_count <= 32'h0;
        end else begin
            if (w_load) begin
                o_fetch_count <= o_fetch_count + 32'd1;
            end
            if (w_redirect) begin
                o_redirect_count <= o_redirect_count + 32'd1;
            end
        end
    end
`endif

    // Read data may only arrive while a request is outstanding
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        i_imem_rvalid |-> w_in_wait);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a transaction-level model with a queue-based skid.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pcCtrl = 2'd0;
    logic        stall = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic [31:0] jalrTarget = 32'h0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = 32'h0;
    logic [31:0] instOut;
    logic [31:0] instPc;
    logic        instValid;
    logic        misalign;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] redirectCount;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pc_ctrl      (pcCtrl),
        .i_stall        (stall),
        .i_branch_target(branchTarget),
        .i_jalr_target  (jalrTarget),
        .o_imem_req     (imemReq),
        .o_imem_addr    (imemAddr),
        .i_imem_ready   (imemReady),
        .i_imem_rvalid  (imemRvalid),
        .i_imem_rdata   (imemRdata),
        .o_inst_out     (instOut),
        .o_inst_pc      (instPc),
        .o_inst_valid   (instValid),
        .o_misalign     (misalign)
`ifdef FETCH_PERF_EN
        ,
        .o_fetch_count   (fetchCount),
        .o_redirect_count(redirectCount)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural view of the fetch unit
    logic [31:0] mPc, mReqPc, mInst, mInstPc;
    logic        mValid, mMis, mBoot, mPending, mKilled;
    logic [63:0] mSkid[$];

    // Memory model: one outstanding read, fixed or random latency
    logic        memPending;
    int          memCountdown;
    logic [31:0] memData;
    int          memLatMin = 1;
    int          memLatMax = 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPc = RESET_PC;
        mReqPc = 32'h0;
        mInst = NOP_INST;
        mInstPc = 32'h0;
        mValid = 1'b0;
        mMis = 1'b0;
        mBoot = 1'b1;
        mPending = 1'b0;
        mKilled = 1'b0;
        mSkid.delete();
        memPending = 1'b0;
        memCountdown = 0;
        memData = 32'h0;
    endtask

    // One clock cycle: entered and left at a falling edge
    task automatic applyStimulus(input logic [1:0] ctrl, input logic stl, input logic [31:0] bTgt,
                                 input logic [31:0] jTgt, input logic rdy);
        logic        rv, expReq, dutReq, redirect, resp, deliver, accept;
        logic [31:0] rd, rawTgt;
        checkOutput("inst_out", instOut, mInst);
        checkOutput("inst_pc", instPc, mInstPc);
        checkOutput("inst_valid", {31'b0, instValid}, {31'b0, mValid});
        checkOutput("misalign", {31'b0, misalign}, {31'b0, mMis});
        rv = memPending && (memCountdown == 0);
        rd = rv ? memData : $urandom;
        pcCtrl = ctrl;
        stall = stl;
        branchTarget = bTgt;
        jalrTarget = jTgt;
        imemReady = rdy;
        imemRvalid = rv;
        imemRdata = rd;
        #1;
        redirect = ctrl[1];
        expReq = !mBoot && !mPending && !redirect && (ctrl != 2'd1) && (mSkid.size() == 0);
        checkOutput("imem_req", {31'b0, imemReq}, {31'b0, expReq});
        checkOutput("imem_addr", imemAddr, mPc);
        dutReq = imemReq;
        @(posedge clk);
        rawTgt = ctrl[0] ? bTgt : jTgt;
        resp = rv && mPending;
        deliver = resp && !mKilled && !redirect;
        accept = expReq && rdy;
        mMis = redirect && (rawTgt[1:0] != 2'b00);
        if (redirect) begin
            mValid = 1'b0;
            mSkid.delete();
        end else if (stl) begin
            if (deliver) mSkid.push_back({rd, mReqPc});
        end else if (mSkid.size() > 0) begin
            {mInst, mInstPc} = mSkid.pop_front();
            mValid = 1'b1;
        end else if (deliver) begin
            mInst = rd;
            mInstPc = mReqPc;
            mValid = 1'b1;
        end else begin
            mValid = 1'b0;
        end
        if (resp) begin
            mPending = 1'b0;
            mKilled = 1'b0;
        end else if (mPending && redirect) begin
            mKilled = 1'b1;
        end
        if (accept) begin
            mPending = 1'b1;
            mKilled = 1'b0;
            mReqPc = mPc;
        end
        if (redirect) mPc = rawTgt & 32'hFFFF_FFFC;
        else if (accept) mPc = mPc + 32'd4;
        mBoot = 1'b0;
        if (rv) memPending = 1'b0;
        else if (memPending) memCountdown--;
        if (dutReq && rdy) begin
            memPending = 1'b1;
            memCountdown = $urandom_range(memLatMax, memLatMin) - 1;
            memData = $urandom;
        end
        @(negedge clk);
    endtask

    task automatic drainIdle();
        for (int i = 0; i < 12 && (mPending || mBoot); i++) begin
            applyStimulus(2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        if (mPending || mBoot) checkOutput("drain_timeout", {31'b0, mPending}, 32'h0);
    endtask

    function automatic logic [31:0] pickTarget();
        logic [31:0] t;
        case ($urandom_range(3, 0))
            0:       t = 32'hFFFF_FFFC;
            1:       t = RESET_PC + ($urandom_range(255, 0) << 2) + $urandom_range(3, 0);
            default: t = $urandom;
        endcase
        return t;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] ctrl;
        int         r;
        modelReset();
        #12;
        checkOutput("rst_inst_out", instOut, NOP_INST);
        checkOutput("rst_inst_pc", instPc, 32'h0);
        checkOutput("rst_valid", {31'b0, instValid}, 32'h0);
        checkOutput("rst_imem_addr", imemAddr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (8) applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        drainIdle();
        memLatMin = 3; memLatMax = 3;
        applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(2'd3, 1'b0, 32'h4000_0100, 32'h0, 1'b1);
        repeat (5) applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        drainIdle();
        memLatMin = 1; memLatMax = 1;
        applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        repeat (3) applyStimulus(2'd0, 1'b1, 32'h0, 32'h0, 1'b1);
        repeat (5) applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        drainIdle();
        applyStimulus(2'd2, 1'b0, 32'h0, 32'h4000_0203, 1'b1);
        repeat (4) applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        drainIdle();
        applyStimulus(2'd3, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        repeat (5) applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        drainIdle();
        memLatMin = 3; memLatMax = 3;
        applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        imemRvalid = 1'b0;
        pcCtrl = 2'd0;
        #1;
        checkOutput("arst_inst_out", instOut, NOP_INST);
        checkOutput("arst_inst_pc", instPc, 32'h0);
        checkOutput("arst_valid", {31'b0, instValid}, 32'h0);
        checkOutput("arst_misalign", {31'b0, misalign}, 32'h0);
        checkOutput("arst_imem_req", {31'b0, imemReq}, 32'h0);
        checkOutput("arst_imem_addr", imemAddr, RESET_PC);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        memLatMin = 1;
        repeat (6) applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);

        memLatMin = 1; memLatMax = 3;
        repeat (3000) begin
            r = $urandom_range(99, 0);
            ctrl = (r < 60) ? 2'd0 : (r < 72) ? 2'd1 : (r < 86) ? 2'd2 : 2'd3;
            applyStimulus(ctrl, $urandom_range(99, 0) < 25, pickTarget(), pickTarget(),
                          $urandom_range(99, 0) < 75);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the decode/control unit in the RV32 pipeline. It owns the PC, issues one instruction-memory read at a time, and presents {instruction, PC, valid} to decode. It obeys the control unit's PC-select and stall outputs, and drops wrong-path fetches on redirect. A 1-entry skid buffer absorbs a response that returns while decode is stalled.

Parameters:
RESET_PC, 32'h4000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, value driven on inst_out during reset (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pc_ctrl  in  2  from control unit: 0 = PC+4, 1 = hold, 2 = JALR target, 3 = branch/JAL target
stall  in  1  from control unit: decode holds its current instruction
branch_target  in  32  target used when pc_ctrl = 3
jalr_target  in  32  target used when pc_ctrl = 2
imem_req  out  1  read request, combinational from state/pc_ctrl
imem_addr  out  32  request address = pc register
imem_ready  in  1  memory accepts request this cycle when imem_req && imem_ready
imem_rvalid  in  1  read data valid; at least 1 cycle after acceptance
imem_rdata  in  32  read data
inst_out  out  32  instruction to decode
inst_pc  out  32  address of inst_out
inst_valid  out  1  inst_out is a live instruction
misalign  out  1  1-cycle pulse: redirect target had [1:0] != 0

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=BOOT, inst_out=NOP_INST, inst_pc=0, inst_valid=0, misalign=0, skid empty, req_pc=0. Release mid-transaction discards any outstanding response.
- Redirect = pc_ctrl in {2,3}. Redirect has priority over stall and hold. Target = selected target with bits [1:0] cleared; misalign=1 on the next cycle if the original bits were nonzero, else 0.
- States:
  - BOOT: one cycle, -> ISSUE.
  - ISSUE: imem_req=1 iff !redirect && pc_ctrl!=1 && skid empty.
    - Accept -> WAIT; req_pc<=pc; pc<=pc+4.
    - Redirect -> stay in ISSUE; pc<=target.
  - WAIT: one request outstanding.
    - rvalid && !redirect: deliver, -> ISSUE.
    - rvalid && redirect: drop response, pc<=target, -> ISSUE.
    - !rvalid && redirect: pc<=target, -> WAIT_KILL.
  - WAIT_KILL: rvalid -> drop response, -> ISSUE. A redirect while in WAIT_KILL updates pc and stays in WAIT_KILL.
- Deliver:
  - If !stall: inst_out<=rdata, inst_pc<=req_pc, inst_valid<=1.
  - If stall: skid<=rdata/req_pc, skid full; outputs held.
- Output register each cycle:
  - Redirect: inst_valid<=0 (bubble), skid cleared.
  - Else if stall: hold all outputs.
  - Else if skid full: outputs<=skid, skid empty.
  - Else if delivering: load as above.
  - Else: inst_valid<=0; inst_out/inst_pc hold.
- pc_ctrl=1 (hold): no request that cycle, pc unchanged; an outstanding response is still delivered.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 0.
- Never more than one outstanding request. Never more than one skid entry.
- imem_rvalid in ISSUE/BOOT is ignored; this is a protocol error and is flagged as an assertion in simulation.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports fetch_count[31:0] (increments per delivered instruction, including skid loads) and redirect_count[31:0] (increments per redirect cycle). Both reset to 0, wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, imem_ready=1, 1-cycle latency, pc_ctrl=0 → addresses 0x4000_0000, 0x4000_0004, 0x4000_0008 issued; inst_pc tracks each with inst_valid=1 one cycle after rvalid.
- pc_ctrl=3, branch_target=0x4000_0100 while a request is outstanding, response arrives 2 cycles later → response dropped, inst_valid=0, next imem_addr=0x4000_0100.
- stall=1 for 3 cycles while a response returns → outputs held, no new imem_req; stall drop → skid instruction appears with correct inst_pc, then fetch resumes.
- pc_ctrl=2, jalr_target=0x4000_0203 → misalign pulses 1 cycle, next fetch at 0x4000_0200.
- pc=0xFFFF_FFFC fetch → next imem_addr=0x0000_0000.
- Async reset asserted while in WAIT → all outputs at reset values immediately; late rvalid after release ignored; first fetch at RESET_PC.
